// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-tick divider, horizontal/vertical raster counters and
// registered sync/blanking/frame-start decode for a VGA timing front end.
// Optional build macro VGA_SYNC_DELAY_EN: H_SYNC, V_SYNC and VIDEO_ON get one
// extra pixel-tick register stage so they line up with a 1-tick synchronous
// image ROM addressed by PIX_X/PIX_Y. Without it they align with PIX_X/PIX_Y.
module vga_sync_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC_W    = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC_W    = 2,
    parameter int V_BACK      = 33,
    parameter int CLK_DIV     = 2,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       EN,
    output logic       PIX_TICK,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
    output logic       VIDEO_ON,
    output logic       H_SYNC,
    output logic       V_SYNC,
    output logic       FRAME_START
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC_W - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC_W - 1);
    localparam logic       SYNC_ON    = 1'(SYNC_ACTIVE);
    localparam logic       SYNC_OFF   = ~SYNC_ON;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             video_on_q, video_on_d;
    logic             h_sync_q, h_sync_d;
    logic             v_sync_q, v_sync_d;
    logic             frame_start_q, frame_start_d;
    logic             pix_tick;

    // Pixel tick: last divider phase while running; the divider holds when EN=0.
    always_comb begin
        pix_tick = EN && (div_q == DIV_LAST);
        div_d    = div_q;
        if (EN) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        end
    end

    // Raster counters: X advances per tick, Y advances on each X wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_tick) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Decode from the next counter values so the registered flags match the
    // coordinates visible in the same cycle.
    always_comb begin
        video_on_d    = (x_d < H_VIS_END) && (y_d < V_VIS_END);
        h_sync_d      = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
        v_sync_d      = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
        frame_start_d = pix_tick && (x_d == 10'd0) && (y_d == 10'd0);
    end

    // Timing state; reset parks the raster on its last pixel so the first tick lands on (0,0).
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            div_q         <= '0;
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            video_on_q    <= 1'b0;
            h_sync_q      <= SYNC_OFF;
            v_sync_q      <= SYNC_OFF;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign PIX_TICK    = pix_tick;
    assign PIX_X       = x_q;
    assign PIX_Y       = y_q;
    assign FRAME_START = frame_start_q;

`ifdef VGA_SYNC_DELAY_EN
    logic video_on_dly_q, video_on_dly_d;
    logic h_sync_dly_q, h_sync_dly_d;
    logic v_sync_dly_q, v_sync_dly_d;

    // One-tick lag stage: captures the flags of the pixel being left on each tick.
    always_comb begin
        video_on_dly_d = video_on_dly_q;
        h_sync_dly_d   = h_sync_dly_q;
        v_sync_dly_d   = v_sync_dly_q;
        if (pix_tick) begin
            video_on_dly_d = video_on_q;
            h_sync_dly_d   = h_sync_q;
            v_sync_dly_d   = v_sync_q;
        end
    end

    // Lag-stage registers, reset to blanked video and inactive sync.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            video_on_dly_q <= 1'b0;
            h_sync_dly_q   <= SYNC_OFF;
            v_sync_dly_q   <= SYNC_OFF;
        end else begin
            video_on_dly_q <= video_on_dly_d;
            h_sync_dly_q   <= h_sync_dly_d;
            v_sync_dly_q   <= v_sync_dly_d;
        end
    end

    assign VIDEO_ON = video_on_dly_q;
    assign H_SYNC   = h_sync_dly_q;
    assign V_SYNC   = v_sync_dly_q;
`else
    assign VIDEO_ON = video_on_q;
    assign H_SYNC   = h_sync_q;
    assign V_SYNC   = v_sync_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen (default build). Instance A uses the 640x480 defaults,
// instance B a tiny raster (25x12, CLK_DIV=3) so whole frames fit in a short run.
// Hand-computed pixel vectors are queued per instance; monitors pop them on PIX_TICK.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic       a_tick, a_vid, a_hs, a_vs, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_vid, b_hs, b_vs, b_fs;
  logic [9:0] b_x, b_y;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int   tick;
    int   x;
    int   y;
    logic vid;
    logic hs;
    logic vs;
  } exp_t;

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];

  // clock / reset block
  always #5 clk = ~clk;

  vga_sync_gen u_a (
    .CLK_IN(clk), .RST_N(rst_n), .EN(en),
    .PIX_TICK(a_tick), .PIX_X(a_x), .PIX_Y(a_y), .VIDEO_ON(a_vid),
    .H_SYNC(a_hs), .V_SYNC(a_vs), .FRAME_START(a_fs)
  );

  vga_sync_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC_W(4), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC_W(2), .V_BACK(2),
    .CLK_DIV(3), .SYNC_ACTIVE(0)
  ) u_b (
    .CLK_IN(clk), .RST_N(rst_n), .EN(en),
    .PIX_TICK(b_tick), .PIX_X(b_x), .PIX_Y(b_y), .VIDEO_ON(b_vid),
    .H_SYNC(b_hs), .V_SYNC(b_vs), .FRAME_START(b_fs)
  );

  task automatic check(input string name, input integer act, input integer exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // frame -1 addresses the parked reset position, which is tick 0
  task automatic push_a(input int frame, input int x, input int y,
                        input logic vid, input logic hs, input logic vs);
    exp_t e;
    e.tick = frame * 420000 + y * 800 + x + 1;
    e.x = x; e.y = y; e.vid = vid; e.hs = hs; e.vs = vs;
    exp_q_a.push_back(e);
  endtask

  task automatic push_b(input int frame, input int x, input int y,
                        input logic vid, input logic hs, input logic vs);
    exp_t e;
    e.tick = frame * 300 + y * 25 + x + 1;
    e.x = x; e.y = y; e.vid = vid; e.hs = hs; e.vs = vs;
    exp_q_b.push_back(e);
  endtask

  task automatic check_reset_values();
    check("rst_a_x", a_x, 799);
    check("rst_a_y", a_y, 524);
    check("rst_a_video_on", a_vid, 0);
    check("rst_a_h_sync", a_hs, 1);
    check("rst_a_v_sync", a_vs, 1);
    check("rst_a_pix_tick", a_tick, 0);
    check("rst_a_frame_start", a_fs, 0);
    check("rst_b_x", b_x, 24);
    check("rst_b_y", b_y, 11);
    check("rst_b_h_sync", b_hs, 1);
    check("rst_b_v_sync", b_vs, 1);
  endtask

  task automatic wait_a(input int x, input int y, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(a_x == 10'(x) && a_y == 10'(y)) && n < budget);
    check("reach_a_xy", int'(a_x) * 1024 + int'(a_y), x * 1024 + y);
  endtask

  // monitor A: pixel vectors on tick, frame-start position and width
  initial begin
    int cnt;
    logic fs_prev;
    exp_t e;
    cnt = 0;
    fs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        fs_prev = 1'b0;
      end else begin
        if (a_fs) begin
          check("a_fs_x", a_x, 0);
          check("a_fs_y", a_y, 0);
          check("a_fs_width", fs_prev, 0);
        end
        fs_prev = a_fs;
        if (a_tick) begin
          while (exp_q_a.size() > 0 && exp_q_a[0].tick < cnt) begin
            e = exp_q_a.pop_front();
            check("a_missed_tick", cnt, e.tick);
          end
          if (exp_q_a.size() > 0 && exp_q_a[0].tick == cnt) begin
            e = exp_q_a.pop_front();
            check("a_x", a_x, e.x);
            check("a_y", a_y, e.y);
            check("a_video_on", a_vid, e.vid);
            check("a_h_sync", a_hs, e.hs);
            check("a_v_sync", a_vs, e.vs);
          end
          cnt++;
        end
      end
    end
  end

  // monitor B: pixel vectors, frame-start checks and frame period in EN-high cycles
  initial begin
    int cnt;
    int en_cycles;
    bit have_fs;
    logic fs_prev;
    exp_t e;
    cnt = 0;
    en_cycles = 0;
    have_fs = 1'b0;
    fs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        have_fs = 1'b0;
        fs_prev = 1'b0;
      end else begin
        if (b_fs) begin
          check("b_fs_x", b_x, 0);
          check("b_fs_y", b_y, 0);
          check("b_fs_width", fs_prev, 0);
          if (have_fs) check("b_frame_period", en_cycles, 900);
          have_fs = 1'b1;
          en_cycles = 0;
        end
        fs_prev = b_fs;
        if (en) en_cycles++;
        if (b_tick) begin
          while (exp_q_b.size() > 0 && exp_q_b[0].tick < cnt) begin
            e = exp_q_b.pop_front();
            check("b_missed_tick", cnt, e.tick);
          end
          if (exp_q_b.size() > 0 && exp_q_b[0].tick == cnt) begin
            e = exp_q_b.pop_front();
            check("b_x", b_x, e.x);
            check("b_y", b_y, e.y);
            check("b_video_on", b_vid, e.vid);
            check("b_h_sync", b_hs, e.hs);
            check("b_v_sync", b_vs, e.vs);
          end
          cnt++;
        end
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // stimulus
  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();

    push_a(-1, 799, 524, 0, 1, 1);
    push_a(0, 0, 0, 1, 1, 1);
    push_a(0, 1, 0, 1, 1, 1);
    push_a(0, 100, 0, 1, 1, 1);
    push_a(0, 101, 0, 1, 1, 1);
    push_a(0, 639, 0, 1, 1, 1);
    push_a(0, 640, 0, 0, 1, 1);
    push_a(0, 655, 0, 0, 1, 1);
    push_a(0, 656, 0, 0, 0, 1);
    push_a(0, 751, 0, 0, 0, 1);
    push_a(0, 752, 0, 0, 1, 1);
    push_a(0, 799, 0, 0, 1, 1);
    push_a(0, 0, 1, 1, 1, 1);
    push_a(0, 299, 1, 1, 1, 1);

    push_b(-1, 24, 11, 0, 1, 1);
    push_b(0, 0, 0, 1, 1, 1);
    push_b(0, 15, 0, 1, 1, 1);
    push_b(0, 16, 0, 0, 1, 1);
    push_b(0, 17, 0, 0, 1, 1);
    push_b(0, 18, 0, 0, 0, 1);
    push_b(0, 21, 0, 0, 0, 1);
    push_b(0, 22, 0, 0, 1, 1);
    push_b(0, 24, 0, 0, 1, 1);
    push_b(0, 0, 1, 1, 1, 1);
    push_b(0, 15, 5, 1, 1, 1);
    push_b(0, 16, 5, 0, 1, 1);
    push_b(0, 0, 6, 0, 1, 1);
    push_b(0, 24, 7, 0, 1, 1);
    push_b(0, 0, 8, 0, 1, 0);
    push_b(0, 19, 8, 0, 0, 0);
    push_b(0, 24, 9, 0, 1, 0);
    push_b(0, 0, 10, 0, 1, 1);
    push_b(0, 24, 11, 0, 1, 1);
    push_b(1, 0, 0, 1, 1, 1);
    push_b(1, 18, 8, 0, 0, 0);
    push_b(2, 0, 0, 1, 1, 1);

    @(negedge clk);
    rst_n = 1'b1;

    // release: tick on the second divider phase, then (0,0) with FRAME_START
    @(posedge clk); #1;
    check("rel1_a_tick", a_tick, 1);
    check("rel1_a_x", a_x, 799);
    @(posedge clk); #1;
    check("rel2_a_tick", a_tick, 0);
    check("rel2_a_x", a_x, 0);
    check("rel2_a_y", a_y, 0);
    check("rel2_a_frame_start", a_fs, 1);
    check("rel2_a_video_on", a_vid, 1);
    @(posedge clk); #1;
    check("rel3_a_tick", a_tick, 1);
    check("rel3_a_frame_start", a_fs, 0);

    // EN gating at X=100 for 37 cycles
    wait_a(100, 0, 400);
    en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(posedge clk); #1;
      check("gate_a_x", a_x, 100);
      check("gate_a_y", a_y, 0);
      check("gate_a_tick", a_tick, 0);
      check("gate_a_video_on", a_vid, 1);
      check("gate_a_h_sync", a_hs, 1);
      check("gate_b_tick", b_tick, 0);
    end
    en = 1'b1;

    // async reset mid-frame, checked before any further clock edge
    wait_a(300, 1, 3000);
    check("queue_a_drained", exp_q_a.size(), 0);
    check("queue_b_drained", exp_q_b.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();

    repeat (3) @(posedge clk);
    push_a(-1, 799, 524, 0, 1, 1);
    push_a(0, 0, 0, 1, 1, 1);
    push_a(0, 1, 0, 1, 1, 1);
    push_b(-1, 24, 11, 0, 1, 1);
    push_b(0, 0, 0, 1, 1, 1);
    push_b(0, 1, 0, 1, 1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("queue_a_final", exp_q_a.size(), 0);
    check("queue_b_final", exp_q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
